iopw_sched: RTL and testbench

IOPW_SCHED -- requirements
Module: iopw_sched

---
 rtl/iopw_sched.sv | 112 +++++++++++
 tb/tb_iopw_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iopw_sched.sv
// rtl/iopw_sched.sv - two-entry posted video-RAM write queue and IO bus engine cycle scheduler.
module iopw_sched (
    input  logic        CLK,
    input  logic        nRES,
    input  logic        PWReq,
    input  logic [22:0] PWA,
    input  logic [15:0] PWD,
    input  logic        PWnUDS,
    input  logic        PWnLDS,
    output logic        PWFull,
    output logic        PWEmpty,
    output logic        PWErr,
    input  logic        IOReq,
    output logic        IOGrant,
    output logic        IOStart,
    input  logic        IODone,
    output logic        IOPWSel,
    output logic [22:0] IOA,
    output logic [15:0] IOD,
    output logic        IOnUDS,
    output logic        IOnLDS
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PW   = 2'd1,
        S_CPU  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [40:0] mem [2];
    logic        push;
    logic        pop;
    logic        io_start;
    logic        pw_err;

    // A push against a full queue is dropped even if the head pops this cycle.
    assign push = PWReq && (count != 2'd2);
    assign pop  = (state == S_PW) && IODone;

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            pw_err <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {PWA, PWD, PWnUDS, PWnLDS};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            if (PWReq && (count == 2'd2)) begin
                pw_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Queue wins over the CPU so posted writes land before any later read.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (count != 2'd0) begin
                    state_nxt = S_PW;
                end else if (IOReq) begin
                    state_nxt = S_CPU;
                end
            end
            S_PW:    if (IODone) state_nxt = S_IDLE;
            S_CPU:   if (IODone) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            io_start <= 1'b0;
        end else begin
            io_start <= (state == S_IDLE) && (state_nxt != S_IDLE);
        end
    end

    always_comb begin
        IOPWSel = (state == S_PW);
        IOGrant = (state == S_CPU);
        IOStart = io_start;
        PWErr   = pw_err;
        PWFull  = (count == 2'd2);
        PWEmpty = (count == 2'd0);
        {IOA, IOD, IOnUDS, IOnLDS} = mem[rd_ptr];
    end

endmodule

// File: tb/tb_iopw_sched.sv
// tb/tb_iopw_sched.sv - directed self-checking bench for iopw_sched.
module tb_iopw_sched;

    logic        CLK;
    logic        nRES;
    logic        PWReq;
    logic [22:0] PWA;
    logic [15:0] PWD;
    logic        PWnUDS;
    logic        PWnLDS;
    logic        PWFull;
    logic        PWEmpty;
    logic        PWErr;
    logic        IOReq;
    logic        IOGrant;
    logic        IOStart;
    logic        IODone;
    logic        IOPWSel;
    logic [22:0] IOA;
    logic [15:0] IOD;
    logic        IOnUDS;
    logic        IOnLDS;

    int total = 0;
    int bad   = 0;

    iopw_sched dut (
        .CLK(CLK), .nRES(nRES),
        .PWReq(PWReq), .PWA(PWA), .PWD(PWD), .PWnUDS(PWnUDS), .PWnLDS(PWnLDS),
        .PWFull(PWFull), .PWEmpty(PWEmpty), .PWErr(PWErr),
        .IOReq(IOReq), .IOGrant(IOGrant), .IOStart(IOStart), .IODone(IODone),
        .IOPWSel(IOPWSel), .IOA(IOA), .IOD(IOD), .IOnUDS(IOnUDS), .IOnLDS(IOnLDS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic post(input logic [22:0] a, input logic [15:0] d, input logic u, input logic l);
        PWReq  = 1'b1;
        PWA    = a;
        PWD    = d;
        PWnUDS = u;
        PWnLDS = l;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_iostart"}, IOStart === 1'b0);
        chk({tag, "_iogrant"}, IOGrant === 1'b0);
        chk({tag, "_iopwsel"}, IOPWSel === 1'b0);
        chk({tag, "_pwerr"},   PWErr   === 1'b0);
        chk({tag, "_pwfull"},  PWFull  === 1'b0);
        chk({tag, "_pwempty"}, PWEmpty === 1'b1);
        chk({tag, "_ioa"},     IOA     === 23'h0);
        chk({tag, "_iod"},     IOD     === 16'h0);
        chk({tag, "_iouds"},   IOnUDS  === 1'b0);
        chk({tag, "_iolds"},   IOnLDS  === 1'b0);
    endtask

    task automatic do_reset();
        nRES = 1'b0;
        tick();
        tick();
        nRES = 1'b1;
        tick();
    endtask

    initial begin
        nRES = 1'b0; PWReq = 1'b0; PWA = '0; PWD = '0; PWnUDS = 1'b0; PWnLDS = 1'b0;
        IOReq = 1'b0; IODone = 1'b0;
        #1;
        tick();
        chk_reset_outputs("rst");
        nRES = 1'b1;
        tick();
        chk_reset_outputs("post_rst");

        post(23'h1FA700, 16'hBEEF, 1'b0, 1'b1);
        tick();
        PWReq = 1'b0;
        chk("t1_c1_empty", PWEmpty === 1'b0);
        chk("t1_c1_start", IOStart === 1'b0);
        tick();
        chk("t1_c2_start", IOStart === 1'b1);
        chk("t1_c2_pwsel", IOPWSel === 1'b1);
        chk("t1_c2_grant", IOGrant === 1'b0);
        chk("t1_c2_ioa",   IOA === 23'h1FA700);
        chk("t1_c2_iod",   IOD === 16'hBEEF);
        chk("t1_c2_uds",   IOnUDS === 1'b0);
        chk("t1_c2_lds",   IOnLDS === 1'b1);
        tick();
        chk("t1_c3_start", IOStart === 1'b0);
        chk("t1_c3_pwsel", IOPWSel === 1'b1);
        tick();
        tick();
        IODone = 1'b1;
        tick();
        IODone = 1'b0;
        chk("t1_c6_empty", PWEmpty === 1'b1);
        chk("t1_c6_pwsel", IOPWSel === 1'b0);

        IOReq = 1'b1;
        tick();
        chk("cpu_c1_start", IOStart === 1'b1);
        chk("cpu_c1_grant", IOGrant === 1'b1);
        chk("cpu_c1_pwsel", IOPWSel === 1'b0);
        IOReq = 1'b0;
        tick();
        chk("cpu_c2_grant", IOGrant === 1'b1);
        chk("cpu_c2_start", IOStart === 1'b0);
        tick();
        chk("cpu_c3_grant", IOGrant === 1'b1);
        IODone = 1'b1;
        tick();
        IODone = 1'b0;
        chk("cpu_c4_grant", IOGrant === 1'b0);
        tick();
        chk("cpu_c5_start", IOStart === 1'b0);

        post(23'h000123, 16'h1111, 1'b0, 1'b0);
        tick();
        PWReq = 1'b0;
        IOReq = 1'b1;
        tick();
        chk("ord_c2_pwsel", IOPWSel === 1'b1);
        chk("ord_c2_start", IOStart === 1'b1);
        chk("ord_c2_grant", IOGrant === 1'b0);
        IODone = 1'b1;
        tick();
        IODone = 1'b0;
        chk("ord_c3_grant", IOGrant === 1'b0);
        chk("ord_c3_start", IOStart === 1'b0);
        chk("ord_c3_pwsel", IOPWSel === 1'b0);
        chk("ord_c3_empty", PWEmpty === 1'b1);
        tick();
        chk("ord_c4_grant", IOGrant === 1'b1);
        chk("ord_c4_start", IOStart === 1'b1);
        IODone = 1'b1;
        tick();
        IODone = 1'b0;
        IOReq  = 1'b0;
        chk("ord_c5_grant", IOGrant === 1'b0);
        tick();

        post(23'h111111, 16'h1234, 1'b0, 1'b0);
        tick();
        PWReq = 1'b0;
        tick();
        chk("s1_c2_start", IOStart === 1'b1);
        chk("s1_c2_ioa",   IOA === 23'h111111);
        post(23'h222222, 16'h5678, 1'b1, 1'b1);
        IODone = 1'b1;
        tick();
        PWReq  = 1'b0;
        IODone = 1'b0;
        chk("s1_c3_empty", PWEmpty === 1'b0);
        chk("s1_c3_full",  PWFull === 1'b0);
        chk("s1_c3_pwsel", IOPWSel === 1'b0);
        chk("s1_c3_ioa",   IOA === 23'h222222);
        chk("s1_c3_iod",   IOD === 16'h5678);
        tick();
        chk("s1_c4_start", IOStart === 1'b1);
        chk("s1_c4_pwsel", IOPWSel === 1'b1);
        IODone = 1'b1;
        tick();
        IODone = 1'b0;
        chk("s1_c5_empty", PWEmpty === 1'b1);
        tick();

        post(23'h0A0001, 16'hAAAA, 1'b0, 1'b0);
        tick();
        post(23'h0B0002, 16'hBBBB, 1'b1, 1'b0);
        IODone = 1'b1;
        chk("ov_c1_full", PWFull === 1'b0);
        tick();
        IODone = 1'b0;
        post(23'h0C0003, 16'hCCCC, 1'b1, 1'b1);
        chk("ov_c2_full",  PWFull === 1'b1);
        chk("ov_c2_err",   PWErr === 1'b0);
        chk("ov_c2_start", IOStart === 1'b1);
        chk("ov_c2_pwsel", IOPWSel === 1'b1);
        chk("ov_c2_ioa",   IOA === 23'h0A0001);
        tick();
        PWReq = 1'b0;
        chk("ov_c3_err",  PWErr === 1'b1);
        chk("ov_c3_full", PWFull === 1'b1);
        tick();
        IODone = 1'b1;
        tick();
        IODone = 1'b0;
        chk("ov_c5_full",  PWFull === 1'b0);
        chk("ov_c5_empty", PWEmpty === 1'b0);
        chk("ov_c5_ioa",   IOA === 23'h0B0002);
        chk("ov_c5_iod",   IOD === 16'hBBBB);
        chk("ov_c5_uds",   IOnUDS === 1'b1);
        chk("ov_c5_lds",   IOnLDS === 1'b0);
        tick();
        chk("ov_c6_start", IOStart === 1'b1);
        chk("ov_c6_pwsel", IOPWSel === 1'b1);
        IODone = 1'b1;
        tick();
        IODone = 1'b0;
        chk("ov_c7_empty", PWEmpty === 1'b1);
        chk("ov_c7_err",   PWErr === 1'b1);
        tick();
        chk("ov_c8_start", IOStart === 1'b0);

        do_reset();
        chk_reset_outputs("rst2");

        post(23'h333333, 16'h3333, 1'b0, 1'b0);
        tick();
        post(23'h444444, 16'h4444, 1'b0, 1'b1);
        tick();
        post(23'h555555, 16'h5555, 1'b1, 1'b0);
        IODone = 1'b1;
        chk("s2_c2_full", PWFull === 1'b1);
        tick();
        PWReq  = 1'b0;
        IODone = 1'b0;
        chk("s2_c3_err",   PWErr === 1'b1);
        chk("s2_c3_full",  PWFull === 1'b0);
        chk("s2_c3_empty", PWEmpty === 1'b0);
        chk("s2_c3_ioa",   IOA === 23'h444444);
        tick();
        chk("s2_c4_start", IOStart === 1'b1);
        chk("s2_c4_ioa",   IOA === 23'h444444);
        IODone = 1'b1;
        tick();
        IODone = 1'b0;
        chk("s2_c5_empty", PWEmpty === 1'b1);

        do_reset();

        post(23'h666666, 16'h6666, 1'b0, 1'b0);
        tick();
        post(23'h777777, 16'h7777, 1'b0, 1'b0);
        tick();
        PWReq = 1'b0;
        chk("rm_c2_full",  PWFull === 1'b1);
        chk("rm_c2_start", IOStart === 1'b1);
        #2;
        nRES = 1'b0;
        #1;
        chk_reset_outputs("rm_async");
        tick();
        tick();
        nRES = 1'b1;
        IODone = 1'b1;
        tick();
        IODone = 1'b0;
        chk_reset_outputs("rm_after");
        tick();
        chk("rm_idle_start", IOStart === 1'b0);
        chk("rm_idle_pwsel", IOPWSel === 1'b0);
        chk("rm_idle_empty", PWEmpty === 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
